// File: rtl/toom8_pointwise_sched_if.sv
// Handshake bundle between the Toom-8 pointwise scheduler and its environment.
// TOOM8_SCHED_PERF_EN adds the cycle_cnt performance counter to the bundle.
interface toom8_pointwise_sched_if #(
  parameter int IDX_W = 4
);
  // mul_issue is the valid for mul_idx and is raised only while mul_ready is
  // high, so a pair transfers in exactly the cycle where both are 1; wr_en is
  // a pure strobe with no back-pressure from the product bank.
  logic             start;
  logic             abort;
  logic             mul_ready;
  logic             mul_issue;
  logic [IDX_W-1:0] mul_idx;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [1:0]       state_dbg;
`ifdef TOOM8_SCHED_PERF_EN
  logic [15:0]      cycle_cnt;
`endif

  modport master (
    output start,
    output abort,
    output mul_ready,
    input  mul_issue,
    input  mul_idx,
    input  wr_en,
    input  wr_idx,
    input  busy,
    input  done,
    input  aborted,
    input  state_dbg
`ifdef TOOM8_SCHED_PERF_EN
    , input cycle_cnt
`endif
  );

  modport slave (
    input  start,
    input  abort,
    input  mul_ready,
    output mul_issue,
    output mul_idx,
    output wr_en,
    output wr_idx,
    output busy,
    output done,
    output aborted,
    output state_dbg
`ifdef TOOM8_SCHED_PERF_EN
    , output cycle_cnt
`endif
  );
endinterface

// File: rtl/toom8_pointwise_sched.sv
// Sequences the 15 Toom-8 pointwise products through one shared pipelined multiplier.
// Optional macro TOOM8_SCHED_PERF_EN adds a saturating busy-cycle counter (cycle_cnt).
module toom8_pointwise_sched #(
  parameter int NUM_PTS = 15,
  parameter int IDX_W   = 4,
  parameter int MUL_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  toom8_pointwise_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] issue_cnt_q;
  logic [IDX_W:0]   retire_cnt_q;
  logic             aborted_q;
  logic [MUL_LAT-1:0] sr_vld_q;
  logic [IDX_W-1:0]   sr_idx_q [MUL_LAT];

  logic in_pass;
  logic issue;
  logic start_acc;
  logic abort_act;
  logic last_issue;
  logic retire;
  logic last_retire;

  assign in_pass     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign issue       = (state_q == S_ISSUE) && bus.mul_ready && !bus.abort;
  assign start_acc   = (state_q == S_IDLE) && bus.start && !bus.abort;
  assign abort_act   = in_pass && bus.abort;
  assign last_issue  = issue && (issue_cnt_q == IDX_W'(NUM_PTS - 1));
  assign retire      = sr_vld_q[MUL_LAT-1];
  assign last_retire = retire && (retire_cnt_q == (IDX_W+1)'(NUM_PTS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_ISSUE;
      S_ISSUE: begin
        if (bus.abort)       state_d = S_IDLE;
        else if (last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.abort)        state_d = S_IDLE;
        else if (last_retire) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      issue_cnt_q  <= '0;
      retire_cnt_q <= '0;
      aborted_q    <= 1'b0;
      sr_vld_q     <= '0;
      for (int i = 0; i < MUL_LAT; i++) sr_idx_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      aborted_q <= abort_act;
      if (start_acc || abort_act) begin
        issue_cnt_q  <= '0;
        retire_cnt_q <= '0;
      end else begin
        if (issue)  issue_cnt_q  <= issue_cnt_q + IDX_W'(1);
        if (retire) retire_cnt_q <= retire_cnt_q + (IDX_W+1)'(1);
      end
      // The in-flight line never stalls: the multiplier has a fixed latency.
      if (abort_act) begin
        sr_vld_q <= '0;
        for (int i = 0; i < MUL_LAT; i++) sr_idx_q[i] <= '0;
      end else begin
        sr_vld_q[0] <= issue;
        sr_idx_q[0] <= issue_cnt_q;
        for (int i = 1; i < MUL_LAT; i++) begin
          sr_vld_q[i] <= sr_vld_q[i-1];
          sr_idx_q[i] <= sr_idx_q[i-1];
        end
      end
    end
  end

`ifdef TOOM8_SCHED_PERF_EN
  logic [15:0] cycle_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
    end else if (start_acc) begin
      cycle_cnt_q <= '0;
    end else if (in_pass && (cycle_cnt_q != 16'hFFFF)) begin
      cycle_cnt_q <= cycle_cnt_q + 16'd1;
    end
  end

  assign bus.cycle_cnt = cycle_cnt_q;
`endif

  assign bus.mul_issue = issue;
  assign bus.mul_idx   = (state_q == S_ISSUE) ? issue_cnt_q : '0;
  assign bus.wr_en     = sr_vld_q[MUL_LAT-1];
  assign bus.wr_idx    = sr_idx_q[MUL_LAT-1];
  assign bus.busy      = in_pass;
  assign bus.done      = (state_q == S_DONE);
  assign bus.aborted   = aborted_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_toom8_pointwise_sched.sv
// Self-checking bench for toom8_pointwise_sched: randomized ready/abort patterns
// against a per-pass schedule model; define TOOM8_SCHED_PERF_EN to cover cycle_cnt.
module tb_toom8_pointwise_sched;

  localparam int NUM_PTS = 15;
  localparam int IDX_W   = 4;
  localparam int LAT     = 4;
  localparam int MAXC    = 96;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  toom8_pointwise_sched_if #(.IDX_W(IDX_W)) bus();

  toom8_pointwise_sched #(
    .NUM_PTS(NUM_PTS),
    .IDX_W  (IDX_W),
    .MUL_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [IDX_W-1:0] exp_q[$];

  // mode: 0 ready always, 1 ready on even cycles, 2 random ready.
  // abort_cyc: 0 = no abort. start_len < 0 holds start through the done cycle.
  task automatic run_pass(input string name, input int mode, input int abort_cyc,
                          input int start_len, input bit done_pulse);
    bit               rdy    [MAXC];
    bit               e_iss  [MAXC];
    logic [IDX_W-1:0] e_idx  [MAXC];
    bit               e_wr   [MAXC];
    bit               e_busy [MAXC];
    bit               e_done [MAXC];
    bit               e_abt  [MAXC];
    int               cnt, last_iss, end_c, total, busy_cycles;
    logic [IDX_W-1:0] got_idx;
    bit               st;

    for (int c = 0; c < MAXC; c++) begin
      if (mode == 0)      rdy[c] = 1'b1;
      else if (mode == 1) rdy[c] = (c % 2 == 0);
      else                rdy[c] = (c >= 50) ? 1'b1 : ($urandom_range(0, 3) != 0);
      e_iss[c] = 0; e_idx[c] = '0; e_wr[c] = 0;
      e_busy[c] = 0; e_done[c] = 0; e_abt[c] = 0;
    end

    // Issues go out in index order on ready cycles from cycle 1 until all are
    // issued or the pass is cancelled; each write lands LAT cycles later.
    cnt = 0; last_iss = 0;
    for (int c = 1; c < MAXC - LAT - 8; c++) begin
      if (abort_cyc > 0 && c >= abort_cyc) break;
      if (cnt < NUM_PTS && rdy[c]) begin
        e_iss[c] = 1;
        e_idx[c] = cnt[IDX_W-1:0];
        last_iss = c;
        cnt++;
      end
    end
    exp_q.delete();
    for (int c = 1; c < MAXC - LAT; c++) begin
      if (e_iss[c] && (abort_cyc == 0 || c + LAT <= abort_cyc)) begin
        e_wr[c+LAT] = 1;
        exp_q.push_back(e_idx[c]);
      end
    end
    if (abort_cyc == 0) begin
      end_c = last_iss + LAT;
      e_done[end_c+1] = 1;
      busy_cycles = end_c;
      total = end_c + 6;
    end else begin
      end_c = abort_cyc;
      e_abt[abort_cyc+1] = 1;
      busy_cycles = abort_cyc;
      total = abort_cyc + LAT + 4;
    end
    for (int c = 1; c <= end_c; c++) e_busy[c] = 1;

    @(posedge clk); #1;
    for (int c = 0; c < total; c++) begin
      if (start_len < 0) st = (c <= end_c + 1);
      else               st = (c < start_len) || (done_pulse && e_done[c]);
      bus.start     = st;
      bus.abort     = (abort_cyc > 0 && c == abort_cyc);
      bus.mul_ready = rdy[c];
      @(negedge clk);
      n_tests++;
      if (bus.mul_issue !== e_iss[c]) begin
        n_fail++;
        $display("FAIL %s mul_issue c=%0d got=%0b exp=%0b", name, c, bus.mul_issue, e_iss[c]);
      end
      if (e_iss[c]) begin
        n_tests++;
        if (bus.mul_idx !== e_idx[c]) begin
          n_fail++;
          $display("FAIL %s mul_idx c=%0d got=%0d exp=%0d", name, c, bus.mul_idx, e_idx[c]);
        end
      end
      n_tests++;
      if (bus.wr_en !== e_wr[c]) begin
        n_fail++;
        $display("FAIL %s wr_en c=%0d got=%0b exp=%0b", name, c, bus.wr_en, e_wr[c]);
      end
      if (bus.wr_en === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s wr_idx c=%0d got=%0d exp=none", name, c, bus.wr_idx);
        end else begin
          got_idx = exp_q.pop_front();
          if (bus.wr_idx !== got_idx) begin
            n_fail++;
            $display("FAIL %s wr_idx c=%0d got=%0d exp=%0d", name, c, bus.wr_idx, got_idx);
          end
        end
      end
      n_tests++;
      if ({bus.busy, bus.done, bus.aborted} !== {e_busy[c], e_done[c], e_abt[c]}) begin
        n_fail++;
        $display("FAIL %s busy/done/aborted c=%0d got=%b exp=%b", name, c,
                 {bus.busy, bus.done, bus.aborted}, {e_busy[c], e_done[c], e_abt[c]});
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.mul_ready = 1'b0;

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_writes got=%0d exp=0", name, exp_q.size());
    end
`ifdef TOOM8_SCHED_PERF_EN
    n_tests++;
    if (bus.cycle_cnt !== 16'(busy_cycles)) begin
      n_fail++;
      $display("FAIL %s cycle_cnt got=%0d exp=%0d", name, bus.cycle_cnt, busy_cycles);
    end
`endif
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.mul_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    n_tests++;
    if ({bus.mul_issue, bus.wr_en, bus.busy, bus.done, bus.aborted, bus.mul_idx, bus.wr_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=0", {bus.mul_issue, bus.wr_en, bus.busy,
               bus.done, bus.aborted, bus.mul_idx, bus.wr_idx});
    end
`ifdef TOOM8_SCHED_PERF_EN
    n_tests++;
    if (bus.cycle_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cycle_cnt got=%0d exp=0", bus.cycle_cnt);
    end
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.busy, bus.wr_en, bus.done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release got=%b exp=000", {bus.busy, bus.wr_en, bus.done});
    end
  endtask

  task automatic test_full_throughput();
    run_pass("full", 0, 0, 1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_pass("alt_ready", 1, 0, 1, 1'b0);
    run_pass("rand_ready", 2, 0, 1, 1'b0);
  endtask

  task automatic test_abort();
    run_pass("abort6", 0, 7, 1, 1'b0);
    run_pass("after_abort", 0, 0, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      run_pass("rand_abort", 2, $urandom_range(1, 15), 1, 1'b0);
      run_pass("rand_after_abort", 2, 0, 1, 1'b0);
    end
  endtask

  task automatic test_start_held();
    run_pass("start_held", 0, 0, -1, 1'b0);
    run_pass("start_in_done", 0, 0, 1, 1'b1);
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mul_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (16) @(posedge clk);
    #3;
    n_tests++;
    if ({bus.busy, bus.wr_en} !== 2'b11) begin
      n_fail++;
      $display("FAIL async_pre_drain got=%b exp=11", {bus.busy, bus.wr_en});
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.mul_issue, bus.wr_en, bus.busy, bus.done, bus.aborted, bus.mul_idx, bus.wr_idx} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs got=%b exp=0", {bus.mul_issue, bus.wr_en, bus.busy,
               bus.done, bus.aborted, bus.mul_idx, bus.wr_idx});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.mul_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.wr_en, bus.busy, bus.done} !== 3'b000) begin
        n_fail++;
        $display("FAIL async_post_reset c=%0d got=%b exp=000", c, {bus.wr_en, bus.busy, bus.done});
      end
    end
    run_pass("restart", 0, 0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) run_pass("b2b", $urandom_range(0, 2), 0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_throughput();
    test_backpressure();
    test_abort();
    test_start_held();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/toom8_pointwise_sched.md
Name: toom8_pointwise_sched

Overview:
- Sequences the 15 Toom-8 pointwise products (points 0, ±1, ±2, ±3, ±4, ±5, ±6, -7, inf) through one shared pipelined signed multiplier instead of 15 parallel multipliers.
- Issues operand-pair indices to the multiplier, tracks in-flight products and raises write strobes into the product bank feeding interpolation.
- Sits between the evaluation stage and the interpolation stage of the TOOM_8 datapath.

Parameters:
- NUM_PTS, 15, number of pointwise products (index 0..NUM_PTS-1; 14 = inf)
- IDX_W, 4, width of product index
- MUL_LAT, 4, fixed multiplier latency in cycles, legal range 1..16

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  request a new pointwise pass; sampled only in IDLE
- abort  input  1  synchronous cancel of the pass in progress
- mul_ready  input  1  multiplier accepts an operand pair this cycle
- mul_issue  output  1  operand pair mul_idx is handed to the multiplier this cycle
- mul_idx  output  IDX_W  index of evaluation point being issued
- wr_en  output  1  product for wr_idx is on the multiplier output this cycle
- wr_idx  output  IDX_W  index of product being written
- busy  output  1  pass in progress (ISSUE or DRAIN)
- done  output  1  one-cycle pulse: all NUM_PTS products written
- aborted  output  1  one-cycle pulse: pass cancelled

Behaviour:
- Reset (async, rst=1): state IDLE; issue/retire counters 0; in-flight shift register cleared; all outputs 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 and abort=0 at an edge -> ISSUE; issue and retire counters cleared. abort has priority over start in the same cycle (start ignored).
- ISSUE: mul_issue = mul_ready & ~abort (combinational); mul_idx = issue counter. The counter increments on each edge with mul_issue=1, so indices go out strictly in order 0..NUM_PTS-1. The edge that issues index NUM_PTS-1 moves to DRAIN. mul_ready=0 stalls issue only; in-flight products still retire.
- In-flight tracking: MUL_LAT-deep shift register of {valid, idx}, advances every cycle, no stall. mul_issue in cycle t gives wr_en=1, wr_idx=idx in cycle t+MUL_LAT. wr_en/wr_idx are registered.
- DRAIN: mul_issue=0. The edge after the cycle carrying wr_en for the NUM_PTS-th retirement moves to DONE.
- DONE: done=1, busy=0 for one cycle, then IDLE. start in DONE is ignored.
- busy=1 exactly in ISSUE and DRAIN.
- abort=1 at an edge in ISSUE/DRAIN: state -> IDLE; shift register and counters cleared; wr_en=0 from the next cycle; aborted=1 for one cycle; done never asserted. abort in IDLE/DONE is ignored.
- Latency at full throughput, start high in cycle 0: issues in cycles 1..NUM_PTS; wr_en in cycles 1+MUL_LAT..NUM_PTS+MUL_LAT; done in cycle NUM_PTS+MUL_LAT+1.
- Each index is written exactly once per completed pass. No duplicates, no reordering.

Optional Feature:
- Macro TOOM8_SCHED_PERF_EN.
- Defined: extra output port cycle_cnt (16 bits). Cleared when start is accepted. Increments every cycle busy=1, saturating at 16'hFFFF. Holds its value after done/aborted until the next accepted start. Reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Full throughput, MUL_LAT=4, mul_ready=1, start pulse cycle 0 -> mul_issue cycles 1..15 with idx 0..14; wr_en cycles 5..19 with idx 0..14; done=1 only in cycle 20; busy high cycles 1..19.
- Backpressure: mul_ready low every other cycle -> issues on ready cycles only, idx order kept; each wr_en lands exactly 4 cycles after its issue; 15 writes total, then one done pulse.
- Abort after 6 issues (idx 0..5 issued) -> aborted pulse next cycle; at most the writes already due in the abort cycle appear, none after; no done; busy=0; a new start then runs a full clean pass.
- start held high for the whole pass, and start pulsed during DONE -> exactly one pass runs; IDLE re-entered; a new pass begins only on the next start seen in IDLE.
- Async rst asserted mid-DRAIN, not clock-aligned -> all outputs 0 immediately; pending wr_en never appears; restart succeeds.
- With TOOM8_SCHED_PERF_EN, full-throughput pass as in the first test -> cycle_cnt = 19 after done and held; stays 19 until the next accepted start.
